// File: rtl/cmd_responder_if.sv
// cmd_responder_if: groups the byte stream and register-bus signals of the
// RS422 command responder.
//
// Signals:
//   newrxstrobe, rxbyte  - byte stream from serialrx (1-cycle strobe + data)
//   xmit, txchar         - 1-cycle push of one byte into the serialtx FIFO
//   reg_addr, reg_wdata  - register bus address / write data
//   reg_we, reg_re       - 1-cycle write / read strobes
//   reg_rdata            - read data, valid the cycle after reg_re
//   frame_active         - high while the responder is busy with a frame
//   err_count            - saturating protocol error count
//
// Handshake semantics: there is no backpressure anywhere. newrxstrobe, xmit,
// reg_we and reg_re are single-cycle qualifiers; the data that goes with each
// is valid only in the cycle its qualifier is high (reg_rdata: the cycle
// after reg_re). The host never has more than one command outstanding.
//
// Modports: slave = the responder, master = the environment (serialrx,
// serialtx FIFO and register file).
interface cmd_responder_if;
  logic       newrxstrobe;
  logic [7:0] rxbyte;
  logic       xmit;
  logic [7:0] txchar;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_active;
  logic [7:0] err_count;

  modport slave (
    input  newrxstrobe, rxbyte, reg_rdata,
    output xmit, txchar, reg_addr, reg_wdata, reg_we, reg_re,
           frame_active, err_count
  );

  modport master (
    output newrxstrobe, rxbyte, reg_rdata,
    input  xmit, txchar, reg_addr, reg_wdata, reg_we, reg_re,
           frame_active, err_count
  );
endinterface

// File: rtl/cmd_responder.sv
// cmd_responder: parses fixed-length read ('R' addr) and write ('W' addr data)
// frames from the host, drives a simple register bus, and queues the reply
// bytes into the serial transmitter FIFO. Unknown opcodes get '?' and bump a
// saturating error counter; stalled partial frames are dropped after
// TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk        - system clock (40 MHz)
//   reset      - synchronous, active-high
//   bus        - cmd_responder_if.slave (byte stream, register bus, status)
//   dbg_state  - current FSM state encoding (state_t), for observation only
//
// Every output is a flop: the output registers are loaded from the next-state
// decode, so a strobe belonging to state S is high exactly while the state
// register holds S.
module cmd_responder #(
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int TO_W           = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  cmd_responder_if.slave       bus,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    R_ADDR = 4'd1,
    RD_REQ = 4'd2,
    RD_CAP = 4'd3,
    TX_A   = 4'd4,
    TX_D   = 4'd5,
    W_ADDR = 4'd6,
    W_DATA = 4'd7,
    WR     = 4'd8,
    ACK    = 4'd9,
    NAK    = 4'd10
  } state_t;

  localparam logic [7:0]      OP_READ  = 8'h52;
  localparam logic [7:0]      OP_WRITE = 8'h57;
  localparam logic [7:0]      RSP_ACK  = 8'h4B;
  localparam logic [7:0]      RSP_NAK  = 8'h3F;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt, to_next;
  logic [7:0]      rd_q, rd_next;
  logic [7:0]      addr_next, wdata_next, txchar_next, err_next;
  logic            err_evt;
  logic            receiving;
  logic            timed_out;

  always_comb begin
    state_next  = state;
    to_next     = '0;
    addr_next   = bus.reg_addr;
    wdata_next  = bus.reg_wdata;
    rd_next     = rd_q;
    err_evt     = 1'b0;
    txchar_next = bus.txchar;
    err_next    = bus.err_count;

    receiving = (state == R_ADDR) || (state == W_ADDR) || (state == W_DATA);
    // A strobe in the same cycle as the timeout takes priority.
    timed_out = receiving && !bus.newrxstrobe && (to_cnt == TO_LAST);

    case (state)
      IDLE: begin
        if (bus.newrxstrobe) begin
          if (bus.rxbyte == OP_READ) begin
            state_next = R_ADDR;
          end else if (bus.rxbyte == OP_WRITE) begin
            state_next = W_ADDR;
          end else begin
            state_next = NAK;
            err_evt    = 1'b1;
          end
        end
      end
      R_ADDR: begin
        if (bus.newrxstrobe) begin
          addr_next  = bus.rxbyte;
          state_next = RD_REQ;
        end
      end
      RD_REQ: state_next = RD_CAP;
      RD_CAP: begin
        rd_next    = bus.reg_rdata;
        state_next = TX_A;
      end
      TX_A:   state_next = TX_D;
      TX_D:   state_next = IDLE;
      W_ADDR: begin
        if (bus.newrxstrobe) begin
          addr_next  = bus.rxbyte;
          state_next = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.newrxstrobe) begin
          wdata_next = bus.rxbyte;
          state_next = WR;
        end
      end
      WR:      state_next = ACK;
      ACK:     state_next = IDLE;
      NAK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Timeout counter: cleared on entry (it rests at zero outside the
    // receiving states) and on every accepted strobe.
    if (timed_out) begin
      state_next = IDLE;
      err_evt    = 1'b1;
    end else if (receiving && !bus.newrxstrobe) begin
      to_next = to_cnt + 1'b1;
    end

    // Strobes that arrive while the block is busy replying are discarded.
    if (bus.newrxstrobe && !receiving && (state != IDLE)) begin
      err_evt = 1'b1;
    end

    if (err_evt && (bus.err_count != 8'hFF)) begin
      err_next = bus.err_count + 8'd1;
    end

    case (state_next)
      TX_A:    txchar_next = bus.reg_addr;
      TX_D:    txchar_next = rd_q;
      ACK:     txchar_next = RSP_ACK;
      NAK:     txchar_next = RSP_NAK;
      default: txchar_next = bus.txchar;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      to_cnt           <= '0;
      rd_q             <= 8'h00;
      bus.xmit         <= 1'b0;
      bus.txchar       <= 8'h00;
      bus.reg_addr     <= 8'h00;
      bus.reg_wdata    <= 8'h00;
      bus.reg_we       <= 1'b0;
      bus.reg_re       <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.err_count    <= 8'h00;
    end else begin
      state            <= state_next;
      to_cnt           <= to_next;
      rd_q             <= rd_next;
      bus.xmit         <= (state_next == TX_A) || (state_next == TX_D) ||
                          (state_next == ACK)  || (state_next == NAK);
      bus.txchar       <= txchar_next;
      bus.reg_addr     <= addr_next;
      bus.reg_wdata    <= wdata_next;
      bus.reg_we       <= (state_next == WR);
      bus.reg_re       <= (state_next == RD_REQ);
      bus.frame_active <= (state_next != IDLE);
      bus.err_count    <= err_next;
    end
  end

  assign dbg_state = state;

endmodule
